tile_map_arbiter: RTL

Shares one single-port synchronous tile RAM holding the 15x20 level grid among four pixel-coordinate requesters: the display pixel pipe (port 0) and three collision probes (ports 1-3). It converts each request's screen (x, y) to a tile address, grants one access per cycle, and returns the 3-bit tile code with a one-cycle ack. Out-of-grid coordinates never touch the RAM and return the out-of-bounds code. It sits between the player/collision logic and the level tile RAM, replacing direct multi-port lookups.

---
 rtl/tile_map_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: 4-port pixel->tile lookup arbiter for the 15x20 tile RAM (req/x/y in, ack/data out, mem_en/mem_addr/mem_rdata to RAM)
module tile_map_arbiter #(
  parameter int unsigned ROW_MAX    = 14,
  parameter int unsigned COL_MAX    = 19,
  parameter int unsigned LEFT       = 144,
  parameter int unsigned TOP        = 35,
  parameter int unsigned TILE_SHIFT = 5,
  parameter int unsigned OOB_TILE   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [9:0] x2,
  input  logic [9:0] x3,
  input  logic [9:0] y0,
  input  logic [9:0] y1,
  input  logic [9:0] y2,
  input  logic [9:0] y3,
  output logic [3:0] ack,
  output logic [2:0] data0,
  output logic [2:0] data1,
  output logic [2:0] data2,
  output logic [2:0] data3,
  output logic       mem_en,
  output logic [8:0] mem_addr,
  input  logic [2:0] mem_rdata
);
  logic [3:0] pending, elig;
  logic [1:0] rr, c1, c2, c3, sel, g_owner, r_owner;
  logic       gnt, oob, g_valid, g_oob, r_valid, r_oob;
  logic [9:0] xs, ys, row, col;
  logic [8:0] addr;
  logic [2:0] data_q [4];
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd3 ? 2'd1 : p + 2'd1;
  endfunction
  assign elig = req & ~pending;
  assign c1 = nxt(rr);
  assign c2 = nxt(c1);
  assign c3 = nxt(c2);
  assign {data0, data1, data2, data3} = {data_q[0], data_q[1], data_q[2], data_q[3]};
  always_comb begin
    gnt  = |elig;
    sel  = elig[0] ? 2'd0 : elig[c1] ? c1 : elig[c2] ? c2 : c3;
    xs   = sel == 2'd0 ? x0 : sel == 2'd1 ? x1 : sel == 2'd2 ? x2 : x3;
    ys   = sel == 2'd0 ? y0 : sel == 2'd1 ? y1 : sel == 2'd2 ? y2 : y3;
    row  = (ys - 10'(TOP)) >> TILE_SHIFT;
    col  = (xs - 10'(LEFT)) >> TILE_SHIFT;
    oob  = row > 10'(ROW_MAX) || col > 10'(COL_MAX);
    addr = 9'(row * 10'(COL_MAX + 1) + col);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      rr       <= 2'd3;
      g_valid  <= 1'b0;
      g_owner  <= '0;
      g_oob    <= 1'b0;
      r_valid  <= 1'b0;
      r_owner  <= '0;
      r_oob    <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      ack      <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      g_valid  <= gnt;
      g_owner  <= sel;
      g_oob    <= oob;
      mem_en   <= gnt && !oob;
      mem_addr <= (gnt && !oob) ? addr : '0;
      r_valid  <= g_valid;
      r_owner  <= g_owner;
      r_oob    <= g_oob;
      ack      <= r_valid ? 4'b0001 << r_owner : '0;
      if (r_valid) data_q[r_owner] <= r_oob ? 3'(OOB_TILE) : mem_rdata;
      pending  <= (pending | (gnt ? 4'b0001 << sel : 4'b0)) & ~(r_valid ? 4'b0001 << r_owner : 4'b0);
      if (gnt && sel != 2'd0) rr <= sel;
    end
  end
endmodule
